// File: rtl/clut_thresh_pkg.sv
// clut_thresh_pkg -- shared types and constants for the clutter-map
// threshold engine (clut_thresh_iir and its per-lane datapath).
//
// Contents:
//   mode_e  : per-frame map update mode (BYPASS / IIR / PEAK / HOLD)
//   state_e : warm-up state machine states (WARM / RUN)
//   LAT     : fixed input-to-output latency in clock cycles
package clut_thresh_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_IIR    = 2'd1,
    MODE_PEAK   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int LAT = 4;

endpackage

// File: rtl/clut_thresh_lane.sv
// clut_thresh_lane -- stages S2..S4 of one clutter-map lane.
//   S2: K*new and (2^KW-K)*old products
//   S3: sum, optional rounding, shift by KW, mode mux
//   S4: offset add with saturation to 2^DW-1
//
// Build option: CLUT_THRESH_ROUND_EN adds 2^(KW-1) before the shift
// (round half up); when undefined the IIR result is truncated.
//
// Ports:
//   sys_clk, rst_n  clock, async active-low reset
//   vld1/vld2/vld3  cell valid at S1/S2/S3 (loads the following stage)
//   mode            effective mode of the cell (warm-up already folded in)
//   k               clamped weight, 0..2^KW
//   ofs             threshold offset for this cell
//   new_smp/old_smp new sample and stored map value
//   map, thr        registered map write-back value and threshold
module clut_thresh_lane
  import clut_thresh_pkg::*;
#(
  parameter int DW = 16,
  parameter int KW = 10
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          vld1,
  input  logic          vld2,
  input  logic          vld3,
  input  logic [1:0]    mode,
  input  logic [KW:0]   k,
  input  logic [DW-1:0] ofs,
  input  logic [DW-1:0] new_smp,
  input  logic [DW-1:0] old_smp,
  output logic [DW-1:0] map,
  output logic [DW-1:0] thr
);

  localparam int PW = DW + KW + 1;   // product width
  localparam int SW = DW + KW + 2;   // sum width
  localparam logic [KW:0] K_ONE = {1'b1, {KW{1'b0}}};

`ifdef CLUT_THRESH_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(1) << (KW - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  // ---------------- S2: multiplies ----------------
  logic [KW:0]   k_inv;
  logic [PW-1:0] s2_pn;
  logic [PW-1:0] s2_po;
  mode_e         s2_mode;
  logic [DW-1:0] s2_new;
  logic [DW-1:0] s2_old;
  logic [DW-1:0] s2_ofs;

  // k never exceeds K_ONE (clamped upstream), so this cannot wrap.
  assign k_inv = K_ONE - k;

  // NOTE: datapath registers have no reset; the valid pipeline qualifies
  // them, so their power-up contents are never observed.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (vld1) begin
      s2_pn   <= PW'(k) * PW'(new_smp);
      s2_po   <= PW'(k_inv) * PW'(old_smp);
      s2_mode <= mode_e'(mode);
      s2_new  <= new_smp;
      s2_old  <= old_smp;
      s2_ofs  <= ofs;
    end
  end

  // ---------------- S3: sum, round, shift, mode mux ----------------
  logic [SW-1:0] sum;
  logic [DW-1:0] iir;
  logic [DW-1:0] map_c;
  logic          unused_sum;

  // The blend is a convex combination, so the shifted result never exceeds
  // max(new, old); the top bits of sum are always zero after the shift.
  assign sum        = SW'(s2_pn) + SW'(s2_po) + RND;
  assign iir        = sum[KW +: DW];
  assign unused_sum = ^{sum[SW-1:KW+DW], sum[KW-1:0]};

  // NOTE: map_c gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    map_c = s2_new;
    case (s2_mode)
      MODE_BYPASS: map_c = s2_new;
      MODE_IIR:    map_c = iir;
      MODE_PEAK:   map_c = (s2_new > s2_old) ? s2_new : s2_old;
      MODE_HOLD:   map_c = s2_old;
      default:     map_c = s2_new;
    endcase
  end

  logic [DW-1:0] s3_map;
  logic [DW-1:0] s3_ofs;

  always_ff @(posedge sys_clk) begin
    if (vld2) begin
      s3_map <= map_c;
      s3_ofs <= s2_ofs;
    end
  end

  // ---------------- S4: offset add and saturation ----------------
  logic [DW:0] thr_sum;

  assign thr_sum = {1'b0, s3_map} + {1'b0, s3_ofs};

  // Outputs hold their last value while no cell is presented.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      map <= '0;
      thr <= '0;
    end else if (vld3) begin
      map <= s3_map;
      thr <= thr_sum[DW] ? '1 : thr_sum[DW-1:0];
    end
  end

endmodule

// File: rtl/clut_thresh_iir.sv
// clut_thresh_iir -- multi-lane recursive clutter-map threshold engine.
// Blends each cell's new power sample with its stored map value using a
// power-of-two fixed-point forgetting factor K = cfg_k / 2^KW, and emits the
// updated map value plus a saturated offset threshold, 4 cycles after input
// in every mode.
//
// Build option: CLUT_THRESH_ROUND_EN selects round-half-up in the IIR blend
// (truncate when undefined). Latency is unaffected.
//
// Ports:
//   sys_clk, rst_n      clock, async active-low reset
//   cfg_mode            0 BYPASS, 1 IIR, 2 PEAK, 3 HOLD (latched at sof)
//   cfg_k               new-sample weight, clamped to 2^KW (latched at sof)
//   cfg_ofs             threshold offset, sampled with each cell
//   cfg_init            pulse, restarts warm-up at the next sof
//   in_vld, in_sof      cell valid / first cell of frame
//   in_new, in_old      new samples and stored map values, lane 0 in LSBs
//   out_vld, out_sof    result valid / sof aligned with the result
//   out_map, out_thr    updated map and threshold per lane
//   out_run             1 when the cell at the output was past warm-up
module clut_thresh_iir
  import clut_thresh_pkg::*;
#(
  parameter int DW          = 16,
  parameter int KW          = 10,
  parameter int NCH         = 1,
  parameter int INIT_FRAMES = 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [1:0]        cfg_mode,
  input  logic [KW:0]       cfg_k,
  input  logic [DW-1:0]     cfg_ofs,
  input  logic              cfg_init,
  input  logic              in_vld,
  input  logic              in_sof,
  input  logic [NCH*DW-1:0] in_new,
  input  logic [NCH*DW-1:0] in_old,
  output logic              out_vld,
  output logic              out_sof,
  output logic [NCH*DW-1:0] out_map,
  output logic [NCH*DW-1:0] out_thr,
  output logic              out_run
);

  localparam int CW = $clog2(INIT_FRAMES + 2);
  localparam logic [KW:0]   K_ONE   = {1'b1, {KW{1'b0}}};
  localparam logic [CW-1:0] RUN_CNT = CW'(INIT_FRAMES + 1);

  // ---------------- frame config snapshot and warm-up FSM ----------------
  state_e        state;
  state_e        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          init_pend;
  logic          init_pend_nxt;
  mode_e         act_mode;
  logic [KW:0]   act_k;

  logic          sof_hit;
  mode_e         mode_in;
  logic [KW:0]   k_clamped;
  logic          restart;

  mode_e         cell_mode;
  logic [KW:0]   cell_k;
  logic          cell_run;

  assign sof_hit   = in_vld & in_sof;
  assign mode_in   = mode_e'(cfg_mode);
  assign k_clamped = (cfg_k > K_ONE) ? K_ONE : cfg_k;
  // A pending or same-cycle init, or a mode change, restarts warm-up at
  // this sof. A K change alone keeps the current state.
  assign restart   = sof_hit & (init_pend | cfg_init | (mode_in != act_mode));

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WARM;
      cnt       <= '0;
      init_pend <= 1'b0;
      act_mode  <= MODE_BYPASS;
      act_k     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_pend <= init_pend_nxt;
      if (sof_hit) begin
        act_mode <= mode_in;
        act_k    <= k_clamped;
      end
    end
  end

  // Next-state logic. A restarting sof counts as warm-up frame 0 (count 1),
  // exactly as the first sof after reset does.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    init_pend_nxt = init_pend;
    if (sof_hit) begin
      init_pend_nxt = 1'b0;
    end else if (cfg_init) begin
      init_pend_nxt = 1'b1;
    end
    if (restart) begin
      state_nxt = ST_WARM;
      cnt_nxt   = CW'(1);
    end else if (sof_hit && state == ST_WARM) begin
      cnt_nxt = cnt + CW'(1);
      if (cnt_nxt == RUN_CNT) begin
        state_nxt = ST_RUN;
      end
    end
  end

  // Output logic: the sof cell already uses the frame's new config and
  // state; later cells of the frame use the snapshot.
  always_comb begin
    cell_mode = sof_hit ? mode_in : act_mode;
    cell_k    = sof_hit ? k_clamped : act_k;
    cell_run  = (state_nxt == ST_RUN);
  end

  // ---------------- S1 registers and control pipeline ----------------
  logic              s1_vld, s2_vld, s3_vld;
  logic              s1_sof, s2_sof, s3_sof;
  logic              s1_run, s2_run, s3_run;
  mode_e             s1_mode;
  logic [KW:0]       s1_k;
  logic [DW-1:0]     s1_ofs;
  logic [NCH*DW-1:0] s1_new;
  logic [NCH*DW-1:0] s1_old;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      out_vld <= 1'b0;
      s1_sof  <= 1'b0;
      s2_sof  <= 1'b0;
      s3_sof  <= 1'b0;
      out_sof <= 1'b0;
      s1_run  <= 1'b0;
      s2_run  <= 1'b0;
      s3_run  <= 1'b0;
      out_run <= 1'b0;
    end else begin
      s1_vld  <= in_vld;
      s2_vld  <= s1_vld;
      s3_vld  <= s2_vld;
      out_vld <= s3_vld;
      s1_sof  <= sof_hit;
      s2_sof  <= s1_sof;
      s3_sof  <= s2_sof;
      out_sof <= s3_sof;
      if (in_vld) s1_run  <= cell_run;
      if (s1_vld) s2_run  <= s1_run;
      if (s2_vld) s3_run  <= s2_run;
      if (s3_vld) out_run <= s3_run;
    end
  end

  // Warm-up is folded into the mode here: a warm cell is simply BYPASS.
  always_ff @(posedge sys_clk) begin
    if (in_vld) begin
      s1_mode <= cell_run ? cell_mode : MODE_BYPASS;
      s1_k    <= cell_k;
      s1_ofs  <= cfg_ofs;
      s1_new  <= in_new;
      s1_old  <= in_old;
    end
  end

  // ---------------- per-lane datapath ----------------
  for (genvar l = 0; l < NCH; l++) begin : g_lane
    clut_thresh_lane #(
      .DW(DW),
      .KW(KW)
    ) u_lane (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .vld1    (s1_vld),
      .vld2    (s2_vld),
      .vld3    (s3_vld),
      .mode    (s1_mode),
      .k       (s1_k),
      .ofs     (s1_ofs),
      .new_smp (s1_new[l*DW +: DW]),
      .old_smp (s1_old[l*DW +: DW]),
      .map     (out_map[l*DW +: DW]),
      .thr     (out_thr[l*DW +: DW])
    );
  end

endmodule

// File: tb/tb_clut_thresh_iir.sv
// tb_clut_thresh_iir -- scoreboard bench for clut_thresh_iir with
// DW=16, KW=10, NCH=4, INIT_FRAMES=2. Stimulus pushes expected results into
// a queue; a monitor on the falling edge pops and compares each output.
// Expected values follow CLUT_THRESH_ROUND_EN when it is defined.
module tb_clut_thresh_iir;
  import clut_thresh_pkg::*;

  localparam int DW          = 16;
  localparam int KW          = 10;
  localparam int NCH         = 4;
  localparam int INIT_FRAMES = 2;
  localparam int VW          = NCH * DW;

`ifdef CLUT_THRESH_ROUND_EN
  localparam longint RND = 512;
  localparam int     RB  = 1;
`else
  localparam longint RND = 0;
  localparam int     RB  = 0;
`endif

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [KW:0]   cfg_k    = '0;
  logic [DW-1:0] cfg_ofs  = '0;
  logic          cfg_init = 1'b0;
  logic          in_vld   = 1'b0;
  logic          in_sof   = 1'b0;
  logic [VW-1:0] in_new   = '0;
  logic [VW-1:0] in_old   = '0;
  logic          out_vld;
  logic          out_sof;
  logic [VW-1:0] out_map;
  logic [VW-1:0] out_thr;
  logic          out_run;

  clut_thresh_iir #(
    .DW(DW), .KW(KW), .NCH(NCH), .INIT_FRAMES(INIT_FRAMES)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .cfg_mode (cfg_mode),
    .cfg_k    (cfg_k),
    .cfg_ofs  (cfg_ofs),
    .cfg_init (cfg_init),
    .in_vld   (in_vld),
    .in_sof   (in_sof),
    .in_new   (in_new),
    .in_old   (in_old),
    .out_vld  (out_vld),
    .out_sof  (out_sof),
    .out_map  (out_map),
    .out_thr  (out_thr),
    .out_run  (out_run)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int            issue;
    logic          sof;
    logic          run;
    logic [VW-1:0] map;
    logic [VW-1:0] thr;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_pass   = 0;
  mode_e f_mode   = MODE_BYPASS;
  int    f_k      = 0;

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [VW-1:0] pack(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [DW-1:0] model_map(input mode_e m, input int k, input logic run,
                                              input logic [DW-1:0] n, input logic [DW-1:0] o);
    int     kk;
    longint s;
    if (!run) return n;
    kk = (k > 1024) ? 1024 : k;
    case (m)
      MODE_BYPASS: return n;
      MODE_IIR: begin
        s = longint'(kk) * longint'(n) + longint'(1024 - kk) * longint'(o) + RND;
        return DW'(s >> KW);
      end
      MODE_PEAK: return (n > o) ? n : o;
      default:   return o;
    endcase
  endfunction

  // Drive one cell with explicitly supplied expected results.
  task automatic send_cell_x(input bit sof, input logic [VW-1:0] nv, input logic [VW-1:0] ov,
                             input int ofs, input bit run_exp, input bit init,
                             input logic [VW-1:0] emap, input logic [VW-1:0] ethr);
    exp_t e;
    @(posedge sys_clk);
    #1;
    in_vld   = 1'b1;
    in_sof   = sof;
    in_new   = nv;
    in_old   = ov;
    cfg_ofs  = DW'(ofs);
    cfg_init = init;
    e.issue  = cyc;
    e.sof    = sof;
    e.run    = run_exp;
    e.map    = emap;
    e.thr    = ethr;
    sb.push_back(e);
  endtask

  // Drive one cell with expected results from the reference model.
  task automatic send_cell(input bit sof, input logic [VW-1:0] nv, input logic [VW-1:0] ov,
                           input int ofs, input bit run_exp, input bit init);
    logic [VW-1:0] emap;
    logic [VW-1:0] ethr;
    int            t;
    if (sof) begin
      f_mode = mode_e'(cfg_mode);
      f_k    = int'(cfg_k);
    end
    for (int l = 0; l < NCH; l++) begin
      emap[l*DW +: DW] = model_map(f_mode, f_k, run_exp, nv[l*DW +: DW], ov[l*DW +: DW]);
      t = int'(emap[l*DW +: DW]) + ofs;
      ethr[l*DW +: DW] = (t > 65535) ? 16'hFFFF : DW'(t);
    end
    send_cell_x(sof, nv, ov, ofs, run_exp, init, emap, ethr);
  endtask

  task automatic send_frame(input int ncell, input bit run_exp, input int seed,
                            input bit has_sof, input bit init0);
    logic [VW-1:0] nv;
    logic [VW-1:0] ov;
    for (int i = 0; i < ncell; i++) begin
      for (int l = 0; l < NCH; l++) begin
        nv[l*DW +: DW] = DW'(seed * 131 + i * 257 + l * 4099);
        ov[l*DW +: DW] = DW'(seed * 977 + i * 61 + l * 7919 + 3);
      end
      send_cell(has_sof && i == 0, nv, ov, 20 + i, run_exp, init0 && i == 0);
    end
  endtask

  task automatic idle();
    @(posedge sys_clk);
    #1;
    in_vld   = 1'b0;
    in_sof   = 1'b0;
    cfg_init = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(posedge sys_clk);
      t++;
    end
    @(negedge sys_clk);
    check("drain_empty", VW'(sb.size()), '0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"}, VW'(out_vld), '0);
    check({tag, "_sof"}, VW'(out_sof), '0);
    check({tag, "_run"}, VW'(out_run), '0);
    check({tag, "_map"}, out_map, '0);
    check({tag, "_thr"}, out_thr, '0);
  endtask

  // Monitor: every presented output must match the oldest expectation and
  // appear exactly LAT cycles after it was issued.
  always @(negedge sys_clk) begin
    if (rst_n && out_vld) begin
      if (sb.size() == 0) begin
        check("spurious_vld", VW'(out_vld), '0);
      end else begin
        mon_e = sb.pop_front();
        check("latency", VW'(cyc - mon_e.issue), VW'(LAT));
        check("out_sof", VW'(out_sof), VW'(mon_e.sof));
        check("out_run", VW'(out_run), VW'(mon_e.run));
        check("out_map", out_map, mon_e.map);
        check("out_thr", out_thr, mon_e.thr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    check_zero("reset");
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Cell before the first sof: warm, not counted
    cfg_mode = 2'd1;
    cfg_k    = 11'd512;
    send_frame(1, 1'b0, 7, 1'b0, 1'b0);

    // IIR warm-up: frames 0 and 1 warm, frame 2 runs
    send_frame(8, 1'b0, 1, 1'b1, 1'b0);
    send_frame(8, 1'b0, 2, 1'b1, 1'b0);
    send_cell_x(1'b1, pack(1000, 0, 65535, 2), pack(2000, 4000, 65535, 6), 10, 1'b1, 1'b0,
                pack(1500, 2000, 65535, 4), pack(1510, 2010, 65535, 14));
    f_mode = MODE_IIR;
    f_k    = 512;
    for (int i = 1; i < 8; i++) begin
      if (i == 3) begin
        cfg_mode = 2'd2;      // ignored mid-frame
        cfg_k    = 11'd100;   // ignored mid-frame
      end
      if (i == 6) begin
        cfg_mode = 2'd1;
        cfg_k    = 11'd512;
      end
      send_cell(1'b0, pack(100 * i, 200 * i, 40000, 7 * i), pack(50 * i, 9000, 100 * i, 3), 30,
                1'b1, i == 4);
    end
    // cfg_init mid frame 2: frame 3 restarts warm-up
    send_frame(8, 1'b0, 3, 1'b1, 1'b0);
    send_frame(4, 1'b0, 4, 1'b1, 1'b0);
    send_frame(4, 1'b1, 5, 1'b1, 1'b0);

    // K change at sof does not restart; K=1 rounding boundary
    cfg_k = 11'd1;
    send_cell_x(1'b1, pack(512, 0, 100, 65535), pack(0, 1000, 100, 0), 5, 1'b1, 1'b0,
                pack(RB, 999, 100, 63 + RB), pack(5 + RB, 1004, 105, 68 + RB));
    f_mode = MODE_IIR;
    f_k    = 1;
    send_frame(3, 1'b1, 6, 1'b0, 1'b0);
    // K above 2^KW clamps to 1.0
    cfg_k = 11'd2047;
    send_frame(4, 1'b1, 8, 1'b1, 1'b0);

    // PEAK: mode change restarts warm-up
    cfg_mode = 2'd2;
    cfg_k    = 11'd512;
    send_frame(2, 1'b0, 9, 1'b1, 1'b0);
    send_frame(2, 1'b0, 10, 1'b1, 1'b0);
    send_cell_x(1'b1, pack(300, 700, 5, 0), pack(700, 300, 5, 65535), 100, 1'b1, 1'b0,
                pack(700, 700, 5, 65535), pack(800, 800, 105, 65535));
    send_cell_x(1'b0, pack(65000, 10, 64535, 64534), pack(10, 65000, 0, 0), 1000, 1'b1, 1'b0,
                pack(65000, 65000, 64535, 64534), pack(65535, 65535, 65535, 65534));
    f_mode = MODE_PEAK;
    f_k    = 512;
    send_frame(2, 1'b1, 11, 1'b0, 1'b0);

    // HOLD
    cfg_mode = 2'd3;
    send_frame(2, 1'b0, 12, 1'b1, 1'b0);
    send_frame(2, 1'b0, 13, 1'b1, 1'b0);
    send_frame(3, 1'b1, 14, 1'b1, 1'b0);

    // IIR then BYPASS with 100 back-to-back cells
    cfg_mode = 2'd1;
    send_frame(2, 1'b0, 15, 1'b1, 1'b0);
    cfg_mode = 2'd0;
    send_frame(100, 1'b0, 16, 1'b1, 1'b0);

    // cfg_init on the sof cycle: that frame is warm-up frame 0
    send_frame(4, 1'b0, 17, 1'b1, 1'b1);
    send_frame(4, 1'b0, 18, 1'b1, 1'b0);
    send_frame(4, 1'b1, 19, 1'b1, 1'b0);
    idle();
    drain();

    // Reset mid-frame drops in-flight cells
    cfg_mode = 2'd1;
    send_frame(3, 1'b0, 20, 1'b1, 1'b0);
    @(posedge sys_clk);
    #2;
    in_vld   = 1'b0;
    in_sof   = 1'b0;
    rst_n    = 1'b0;
    sb.delete();
    #1;
    check_zero("midrst");
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (10) @(posedge sys_clk);
    #1;
    check("post_rst_idle_vld", VW'(out_vld), '0);
    send_frame(1, 1'b0, 21, 1'b0, 1'b0);
    idle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clut_thresh_iir.md
# clut_thresh_iir

Parametrised, multi-lane recursive clutter-map threshold engine for the clutter-map path. It blends each cell's new power sample with the stored map value, using a power-of-two fixed-point forgetting factor (no /1000 divider). It also supports per-frame mode selection and warm-up frames after start or re-initialisation. It produces the updated map value for write-back and a saturated offset threshold, at a fixed latency identical in every mode.

## Interface
Parameters:
- DW, 16: sample/map width per lane.
- KW, 10: fractional bits of K; K = cfg_k / 2^KW.
- NCH, 1: parallel lanes sharing one valid.
- INIT_FRAMES, 1: warm-up frame count, at least 1.

Ports (clock and reset: sys_clk, rst_n; reset is asynchronous, active-low):
- sys_clk  in  1  clock
- rst_n  in  1  async active-low reset
- cfg_mode  in  2  0 BYPASS, 1 IIR, 2 PEAK, 3 HOLD
- cfg_k  in  KW+1  weight of new sample; values above 2^KW clamp to 2^KW
- cfg_ofs  in  DW  threshold offset
- cfg_init  in  1  pulse, requests warm-up restart
- in_vld  in  1  cell valid
- in_sof  in  1  first cell of frame, qualified by in_vld
- in_new  in  NCH*DW  new samples, lane 0 in LSBs
- in_old  in  NCH*DW  stored map values
- out_vld  out  1  result valid
- out_sof  out  1  in_sof delayed
- out_map  out  NCH*DW  updated map for write-back
- out_thr  out  NCH*DW  threshold
- out_run  out  1  1 when the active frame is past warm-up

## Operation
- Config snapshot: on in_vld && in_sof, cfg_mode and cfg_k (clamped) are latched as the active config for the whole frame. Mid-frame cfg changes are ignored.
- Per-lane map computation, with n = new and o = old:
  - BYPASS: n.
  - IIR: (K·n + (2^KW−K)·o + R) >> KW. Products are DW+KW+1 bits; the sum is DW+KW+2 bits. R = 2^(KW−1) with rounding enabled, 0 otherwise. The result never exceeds max(n,o), so it fits DW bits.
  - PEAK: max(n,o).
  - HOLD: o.
- Threshold: out_thr = min(map + cfg_ofs, 2^DW−1). cfg_ofs is sampled with the cell, not with the frame.
- Warm-up state machine (states WARM, RUN):
  - Reset enters WARM with frame count 0.
  - In WARM, the map is n regardless of mode.
  - Each sof seen in WARM increments the count. The sof that makes the count reach INIT_FRAMES+1 switches the state to RUN for that frame.
  - Cells before the first sof after reset are processed as WARM and are not counted.
- cfg_init sets a pending flag. The next sof clears it, returns to WARM, and counts that frame as warm-up frame 0.
- An active-mode change detected at sof has the same effect as cfg_init. A K change does not.
- cfg_init asserted in the same cycle as sof: that sof begins warm-up frame 0.
- out_run shows the state applied to the cell currently at the output.

## Timing
- Pipeline stages:
  - S1: input, config and state register.
  - S2: multiplies.
  - S3: sum, round, shift and mode mux.
  - S4: offset add and saturation.
- Latency is exactly 4 cycles from in_vld to out_vld in all modes, including BYPASS. out_sof, out_map and out_thr are aligned with out_vld.
- Accepts one cell per cycle; back-to-back valid is supported with no stall and no backpressure.
- When out_vld is 0, out_map and out_thr hold their last values.
- Reset values: out_vld 0, out_sof 0, out_map 0, out_thr 0, out_run 0. Pipeline valids are cleared and the pending-init flag is cleared.
- Reset mid-frame drops all in-flight cells. No output appears until 4 cycles after the first post-reset in_vld.

## Configuration
- CLUT_THRESH_ROUND_EN:
  - Defined: the IIR path adds R = 2^(KW−1) before the shift (round half up).
  - Undefined: R = 0 (truncate).
- No other behaviour or latency changes.

## Structure
- Package clut_thresh_pkg contains:
  - the mode enum (BYPASS/IIR/PEAK/HOLD);
  - the state enum (WARM/RUN);
  - the pipeline latency constant LAT = 4.
- Sub-module clut_thresh_lane (stages S2–S4 for one lane), instantiated NCH times.
- The top level owns the S1 registers, the config snapshot, the warm-up state machine and valid/sof alignment.

## Test plan
- IIR at DW=16, KW=10, K=512, run state, new 1000, old 2000 -> out_map 1500 exactly 4 cycles later.
- K=1, new 512, old 0 -> out_map 1 with CLUT_THRESH_ROUND_EN, 0 without.
- PEAK, new 300, old 700, ofs 100 -> map 700, thr 800. Map 65000 with ofs 1000 -> thr 65535.
- INIT_FRAMES=2, mode IIR, 3 frames of 8 cells -> frames 0–1 give map = new with out_run 0; frame 2 gives the IIR result with out_run 1. cfg_init mid-frame 2 -> frame 3 is warm-up.
- Mode change at sof from IIR to BYPASS, with 100 back-to-back cells -> 100 contiguous outputs, no gap, BYPASS latency still 4.
- NCH=4, distinct lane data -> each lane correct. rst_n pulsed mid-frame -> all outputs 0, no stale out_vld.
